// File: rtl/drbg_keystream_buffer_if.sv
// DRBG-side and consumer-side signal bundle for the keystream buffer.
// The buffer connects through the slave modport; the DRBG/consumer environment uses master.
interface drbg_keystream_buffer_if #(
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 2
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 drbg_init_ready;
  logic                 drbg_next_bits;
  logic                 drbg_next_bits_ready;
  logic [255:0]         drbg_random_bits;
  logic                 key_req;
  logic                 key_valid;
  logic [OUT_WIDTH-1:0] key_word;
  logic                 flush;
  logic [LVL_W-1:0]     level;
  logic                 underflow;

  modport slave (
    input  drbg_init_ready, drbg_next_bits_ready, drbg_random_bits, key_req, flush,
    output drbg_next_bits, key_valid, key_word, level, underflow
  );

  modport master (
    output drbg_init_ready, drbg_next_bits_ready, drbg_random_bits, key_req, flush,
    input  drbg_next_bits, key_valid, key_word, level, underflow
  );
endinterface

// File: rtl/drbg_keystream_buffer.sv
// Buffers DEPTH 256-bit DRBG words and hands them out as OUT_WIDTH keystream slices,
// LSB slice first, with a fetch FSM that keeps the buffer topped up.
module drbg_keystream_buffer #(
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  drbg_keystream_buffer_if.slave  io_bus
);
  localparam int SLICES = 256 / OUT_WIDTH;
  localparam int PTR_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int SLOT_W = $clog2(DEPTH);
  localparam int LVL_W  = SLOT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLICES - 1);
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} fetch_state_t;

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic                 r_rdy_prev;
  logic [255:0]         r_mem [DEPTH];
  logic [SLOT_W-1:0]    r_wr_slot;
  logic [SLOT_W-1:0]    r_rd_slot;
  logic [PTR_W-1:0]     r_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_key_valid;
  logic [OUT_WIDTH-1:0] r_key_word;
  logic                 r_underflow;

  logic                 w_rdy_rise;
  logic                 w_capture;
  logic                 w_have_data;
  logic                 w_serve;
  logic                 w_starve;
  logic                 w_head_free;
  logic [255:0]         w_head;
  logic [OUT_WIDTH-1:0] w_slices [SLICES];

  assign w_rdy_rise  = io_bus.drbg_next_bits_ready & ~r_rdy_prev;
  assign w_have_data = (r_level != '0);
  assign w_serve     = io_bus.key_req & w_have_data & ~io_bus.flush;
  assign w_starve    = io_bus.key_req & ~w_have_data & ~io_bus.flush;
  assign w_head_free = w_serve & (r_ptr == LAST_PTR);

  assign w_head = r_mem[r_rd_slot];
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign w_slices[gi] = w_head[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  // Losing init_ready aborts any fetch in progress; an uncaptured word is dropped.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    if (!io_bus.drbg_init_ready) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_level < FULL) w_state_next = REQ;
        end
        REQ: begin
          if (io_bus.flush) begin
            w_state_next = WAIT_LOW;
          end else if (w_rdy_rise) begin
            w_capture    = 1'b1;
            w_state_next = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!io_bus.drbg_next_bits_ready) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rdy_prev <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rdy_prev <= io_bus.drbg_next_bits_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_capture) r_mem[r_wr_slot] <= io_bus.drbg_random_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_ptr       <= '0;
      r_level     <= '0;
      r_key_valid <= 1'b0;
      r_key_word  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_key_valid <= w_serve;
      if (w_serve)  r_key_word  <= w_slices[r_ptr];
      if (w_starve) r_underflow <= 1'b1;
      if (io_bus.flush) begin
        r_wr_slot <= '0;
        r_rd_slot <= '0;
        r_ptr     <= '0;
        r_level   <= '0;
      end else begin
        if (w_capture)   r_wr_slot <= r_wr_slot + 1'b1;
        if (w_head_free) r_rd_slot <= r_rd_slot + 1'b1;
        if (w_serve)     r_ptr     <= w_head_free ? '0 : r_ptr + 1'b1;
        // A capture and a head release in the same cycle leave the level unchanged.
        if (w_capture && !w_head_free)      r_level <= r_level + 1'b1;
        else if (!w_capture && w_head_free) r_level <= r_level - 1'b1;
      end
    end
  end

  assign io_bus.drbg_next_bits = (r_state == REQ);
  assign io_bus.key_valid      = r_key_valid;
  assign io_bus.key_word       = r_key_word;
  assign io_bus.level          = r_level;
  assign io_bus.underflow      = r_underflow;
endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// Self-checking bench: a slice-queue model of the keystream, directed scenarios with literal
// expectations, then a randomized phase with a responsive DRBG stand-in.
module tb_drbg_keystream_buffer;
  localparam int OW    = 8;
  localparam int DEPTH = 2;
  localparam int SL    = 256 / OW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drbg_keystream_buffer_if #(.OUT_WIDTH(OW), .DEPTH(DEPTH)) bus ();
  drbg_keystream_buffer #(.OUT_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // DRBG stand-in: automatic responder or manual control from the stimulus
  logic         auto_drbg;
  logic         drv_ready, man_ready;
  logic [255:0] drv_word, man_word;
  logic [255:0] dq[$];
  assign bus.drbg_next_bits_ready = auto_drbg ? drv_ready : man_ready;
  assign bus.drbg_random_bits     = auto_drbg ? drv_word  : man_word;

  // Model state: pending keystream slices in output order
  logic [OW-1:0] q[$];
  logic          exp_valid, exp_uf, armed;
  logic [OW-1:0] exp_word;
  logic          rdy_prev_m, init_prev, cap_prev, reset_prev;
  int            stall_cnt, cap_count;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_level();
    return (q.size() + SL - 1) / SL;
  endfunction

  function automatic logic [255:0] pat(input logic [7:0] base);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  function automatic logic [255:0] rnd_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare then model-advance, both at the negedge when inputs and outputs are stable
  initial begin
    logic rise, cap;
    armed = 1'b0; exp_valid = 1'b0; exp_word = '0; exp_uf = 1'b0;
    rdy_prev_m = 1'b0; init_prev = 1'b0; cap_prev = 1'b0; reset_prev = 1'b1;
    stall_cnt = 0; cap_count = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("key_valid", bus.key_valid, exp_valid);
        chk("key_word", bus.key_word, exp_word);
        chk("level", bus.level, exp_level());
        chk("underflow", bus.underflow, exp_uf);
        if (bus.drbg_next_bits) begin
          chk("nb_level_room", exp_level() < DEPTH, 1'b1);
          chk("nb_init_prev", init_prev, 1'b1);
          chk("nb_after_capture", cap_prev, 1'b0);
          chk("nb_after_reset", reset_prev, 1'b0);
        end
        if (!reset && !bus.flush && bus.drbg_init_ready && !bus.drbg_next_bits_ready &&
            !bus.drbg_next_bits && exp_level() < DEPTH)
          stall_cnt++;
        else
          stall_cnt = 0;
        chk("fetch_stall", stall_cnt < 4, 1'b1);
      end
      cap = 1'b0;
      if (reset) begin
        q.delete();
        exp_valid = 1'b0; exp_word = '0; exp_uf = 1'b0;
        rdy_prev_m = 1'b0; cap_count = 0; armed = 1'b1;
      end else begin
        rise = bus.drbg_next_bits_ready && !rdy_prev_m;
        cap  = bus.drbg_next_bits && bus.drbg_init_ready && rise && !bus.flush;
        exp_valid = 1'b0;
        if (bus.flush) begin
          q.delete();
        end else begin
          if (bus.key_req) begin
            if (q.size() > 0) begin
              exp_valid = 1'b1;
              exp_word  = q.pop_front();
            end else begin
              exp_uf = 1'b1;
            end
          end
          if (cap) begin
            for (int k = 0; k < SL; k++) q.push_back(bus.drbg_random_bits[k*OW +: OW]);
            cap_count++;
          end
        end
        rdy_prev_m = bus.drbg_next_bits_ready;
      end
      init_prev  = bus.drbg_init_ready;
      cap_prev   = cap;
      reset_prev = reset;
    end
  end

  // Automatic DRBG responder with random latency, hold time and occasional spurious pulses
  initial begin
    int st, dly, hold;
    st = 0; dly = 0; hold = 0;
    drv_ready = 1'b0; drv_word = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_drbg) begin
        drv_ready = 1'b0;
        st = 0;
      end else begin
        case (st)
          0: begin
            if (bus.drbg_next_bits) begin
              dly = $urandom_range(0, 3);
              st = 1;
            end else if ($urandom_range(0, 40) == 0) begin
              drv_word = rnd_word(); drv_ready = 1'b1; hold = $urandom_range(0, 2); st = 2;
            end
          end
          1: begin
            if (dly == 0) begin
              drv_word  = (dq.size() > 0) ? dq.pop_front() : rnd_word();
              drv_ready = 1'b1;
              hold = $urandom_range(0, 2);
              st = 2;
            end else dly--;
          end
          default: begin
            if (hold == 0) begin
              drv_ready = 1'b0;
              st = 0;
            end else hold--;
          end
        endcase
      end
    end
  end

  task automatic wait_nb(input string nm);
    int n = 0;
    while (!bus.drbg_next_bits && n < 50) begin cyc(); n++; end
    chk(nm, bus.drbg_next_bits, 1'b1);
  endtask

  task automatic man_capture(input logic [255:0] w);
    wait_nb("man_next_bits");
    man_word = w; man_ready = 1'b1;
    cyc();
    man_ready = 1'b0;
  endtask

  task automatic read_one(input string nm, input logic [7:0] exp);
    bus.key_req = 1'b1;
    cyc();
    bus.key_req = 1'b0;
    chk({nm, "_valid"}, bus.key_valid, 1'b1);
    chk({nm, "_word"}, bus.key_word, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; bus.drbg_init_ready = 1'b0; bus.key_req = 1'b0; bus.flush = 1'b0;
    auto_drbg = 1'b0; man_ready = 1'b0; man_word = '0;
    repeat (3) cyc();
    chk("rst_level", bus.level, 0);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_word", bus.key_word, 0);
    chk("rst_next_bits", bus.drbg_next_bits, 0);
    chk("rst_underflow", bus.underflow, 0);
    reset = 1'b0;
    repeat (4) begin cyc(); chk("nb_without_init", bus.drbg_next_bits, 0); end

    // Fill two words, then the FSM must stay quiet
    dq.push_back(pat(8'h00)); dq.push_back(pat(8'h20));
    auto_drbg = 1'b1; bus.drbg_init_ready = 1'b1;
    n = 0;
    while (bus.level != 2 && n < 200) begin cyc(); n++; end
    chk("fill_level", bus.level, 2);
    repeat (10) begin cyc(); chk("full_next_bits", bus.drbg_next_bits, 0); end
    chk("fill_handshakes", cap_count, 2);

    // Drain word0 slice by slice, back-to-back
    for (int k = 0; k < 32; k++) read_one("drain", k[7:0]);
    chk("drain_level", bus.level, 1);
    wait_nb("refetch_start");

    // Underflow, then sticky through a valid read
    bus.drbg_init_ready = 1'b0;
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush_empty_level", bus.level, 0);
    cyc();
    bus.key_req = 1'b1;
    cyc();
    bus.key_req = 1'b0;
    chk("uf_no_valid", bus.key_valid, 0);
    chk("uf_flag", bus.underflow, 1);
    bus.drbg_init_ready = 1'b1;
    n = 0;
    while (bus.level == 0 && n < 100) begin cyc(); n++; end
    chk("uf_refill", bus.level != 0, 1'b1);
    bus.key_req = 1'b1;
    cyc();
    bus.key_req = 1'b0;
    chk("uf_read_valid", bus.key_valid, 1);
    chk("uf_held", bus.underflow, 1);

    // Last slice of the head consumed in the same cycle as a capture
    auto_drbg = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    man_capture(pat(8'h40));
    chk("sim_pre_level", bus.level, 1);
    for (int k = 0; k < 31; k++) read_one("sim_head", 8'h40 + 8'(k));
    wait_nb("sim_next_bits");
    man_word = pat(8'h80); man_ready = 1'b1; bus.key_req = 1'b1;
    cyc();
    man_ready = 1'b0; bus.key_req = 1'b0;
    chk("sim_valid", bus.key_valid, 1);
    chk("sim_word", bus.key_word, 8'h5F);
    chk("sim_level", bus.level, 1);
    read_one("sim_new_slice0", 8'h80);

    // Flush mid-word after five reads of the new word
    for (int k = 1; k < 5; k++) read_one("pre_flush", 8'h80 + 8'(k));
    bus.flush = 1'b1; bus.key_req = 1'b1;
    cyc();
    bus.flush = 1'b0; bus.key_req = 1'b0;
    chk("flush_valid", bus.key_valid, 0);
    chk("flush_level", bus.level, 0);
    chk("flush_no_underflow", bus.underflow, 0);
    man_capture(pat(8'hC0));
    read_one("post_flush", 8'hC0);

    // Reset while requesting a word with data still buffered
    wait_nb("pre_reset_next_bits");
    reset = 1'b1; bus.key_req = 1'b1;
    cyc();
    reset = 1'b0; bus.key_req = 1'b0;
    chk("mid_rst_next_bits", bus.drbg_next_bits, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.key_valid, 0);
    chk("mid_rst_word", bus.key_word, 0);
    chk("mid_rst_underflow", bus.underflow, 0);
    man_capture(pat(8'hE0));
    read_one("post_reset", 8'hE0);

    // Randomized traffic against the model
    auto_drbg = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (((c / 500) % 2) == 0) bus.key_req = ($urandom_range(0, 1) == 0);
      else                      bus.key_req = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 199) == 0) bus.drbg_init_ready = ~bus.drbg_init_ready;
      cyc();
    end
    bus.key_req = 1'b0; bus.flush = 1'b0; reset = 1'b0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
